ucode_sequencer: RTL and testbench

//  Microcode responder for iFetch's multiply expansion. Captures a multiply instruction's opcode/operands
//  at issue and returns the 32-bit ghost_instruction addressed by ghost_PC, with operands substituted.

---
 rtl/ucode_pkg.sv | 59 +++++
 rtl/ucode_rom.sv | 59 +++++
 rtl/ucode_sequencer.sv | 107 ++++++++++
 tb/tb_ucode_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucode_pkg.sv
// Shared constants for the multiply microcode sequencer: opcodes, template fields,
// routine lengths and the sequencer state type.
package ucode_pkg;

    localparam int          UC_DEPTH = 16;
    localparam logic [31:0] NOP_WORD = 32'hC800_0000;

    // Multiply opcodes expanded by the sequencer (signed/unsigned x reg/imm)
    localparam logic [6:0] OP_MUL_SR = 7'b0010000;
    localparam logic [6:0] OP_MUL_UR = 7'b0011000;
    localparam logic [6:0] OP_MUL_SI = 7'b0110000;
    localparam logic [6:0] OP_MUL_UI = 7'b0111000;

    localparam logic [3:0] SEL_RD = 4'hF;
    localparam logic [3:0] SEL_RS = 4'hE;

    localparam logic [4:0] LEN_SR = 5'd8;
    localparam logic [4:0] LEN_UR = 5'd6;
    localparam logic [4:0] LEN_SI = 5'd4;
    localparam logic [4:0] LEN_UI = 5'd3;

    localparam logic [6:0] UOP_MOV = 7'b0000001;
    localparam logic [6:0] UOP_ADD = 7'b0000010;
    localparam logic [6:0] UOP_SHL = 7'b0000011;
    localparam logic [6:0] UOP_SHR = 7'b0000100;
    localparam logic [6:0] UOP_AND = 7'b0000101;
    localparam logic [6:0] UOP_LDI = 7'b0000110;
    localparam logic [6:0] UOP_NEG = 7'b0000111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_mul_op(input logic [6:0] op);
        return (op == OP_MUL_SR) || (op == OP_MUL_UR) ||
               (op == OP_MUL_SI) || (op == OP_MUL_UI);
    endfunction

    function automatic logic [4:0] routine_len(input logic [6:0] op);
        logic [4:0] len;
        case (op)
            OP_MUL_SR: len = LEN_SR;
            OP_MUL_UR: len = LEN_UR;
            OP_MUL_SI: len = LEN_SI;
            OP_MUL_UI: len = LEN_UI;
            default:   len = 5'd1;
        endcase
        return len;
    endfunction

    // Template layout: {uop, rd/selector, rs/selector, substitute-imm flag, imm}
    function automatic logic [31:0] tmpl(input logic [6:0] uop, input logic [3:0] rd,
                                         input logic [3:0] rs, input logic sub,
                                         input logic [15:0] imm);
        return {uop, rd, rs, sub, imm};
    endfunction

endpackage

// File: rtl/ucode_rom.sv
// Combinational template store: (opcode, line) -> 32-bit micro-instruction template.
// Lines past a routine's end read as NOP_WORD.
module ucode_rom
    import ucode_pkg::*;
(
    input  logic [6:0]  op,
    input  logic [3:0]  line,
    output logic [31:0] template
);

    always_comb begin
        template = NOP_WORD;
        case (op)
            OP_MUL_SR: begin
                case (line)
                    4'd0:    template = tmpl(UOP_ADD, SEL_RD, SEL_RS, 1'b0, 16'h0000);
                    4'd1:    template = tmpl(UOP_MOV, 4'h1,   SEL_RS, 1'b0, 16'h0000);
                    4'd2:    template = tmpl(UOP_LDI, 4'h2,   4'h0,   1'b0, 16'h0010);
                    4'd3:    template = tmpl(UOP_AND, 4'h3,   4'h1,   1'b0, 16'h0001);
                    4'd4:    template = tmpl(UOP_SHL, 4'h1,   4'h1,   1'b0, 16'h0001);
                    4'd5:    template = tmpl(UOP_SHR, SEL_RS, SEL_RS, 1'b0, 16'h0001);
                    4'd6:    template = tmpl(UOP_NEG, SEL_RD, SEL_RD, 1'b0, 16'h0000);
                    4'd7:    template = tmpl(UOP_ADD, SEL_RD, 4'h2,   1'b0, 16'h0000);
                    default: template = NOP_WORD;
                endcase
            end
            OP_MUL_UR: begin
                case (line)
                    4'd0:    template = tmpl(UOP_MOV, 4'h1,   SEL_RD, 1'b0, 16'h0000);
                    4'd1:    template = tmpl(UOP_MOV, 4'h2,   SEL_RS, 1'b0, 16'h0000);
                    4'd2:    template = tmpl(UOP_LDI, SEL_RD, 4'h0,   1'b0, 16'h0000);
                    4'd3:    template = tmpl(UOP_AND, 4'h3,   4'h2,   1'b0, 16'h0001);
                    4'd4:    template = tmpl(UOP_SHL, 4'h1,   4'h1,   1'b0, 16'h0001);
                    4'd5:    template = tmpl(UOP_ADD, SEL_RD, 4'h1,   1'b0, 16'h0000);
                    default: template = NOP_WORD;
                endcase
            end
            OP_MUL_SI: begin
                case (line)
                    4'd0:    template = tmpl(UOP_LDI, 4'h2,   4'h0,   1'b1, 16'h0000);
                    4'd1:    template = tmpl(UOP_MOV, 4'h1,   SEL_RS, 1'b0, 16'h0000);
                    4'd2:    template = tmpl(UOP_SHL, 4'h1,   4'h1,   1'b0, 16'h0004);
                    4'd3:    template = tmpl(UOP_ADD, SEL_RD, 4'h1,   1'b1, 16'h0000);
                    default: template = NOP_WORD;
                endcase
            end
            OP_MUL_UI: begin
                case (line)
                    4'd0:    template = tmpl(UOP_LDI, 4'h2,   4'h0,   1'b1, 16'h0000);
                    4'd1:    template = tmpl(UOP_AND, SEL_RD, SEL_RS, 1'b0, 16'hFFFF);
                    4'd2:    template = tmpl(UOP_ADD, SEL_RD, 4'h2,   1'b0, 16'h0000);
                    default: template = NOP_WORD;
                endcase
            end
            default: template = NOP_WORD;
        endcase
    end

endmodule

// File: rtl/ucode_sequencer.sv
// Multiply-expansion microcode responder: captures the issuing instruction, then serves
// operand-substituted template lines indexed by fetch's ghost_PC and checks the line protocol.
module ucode_sequencer
    import ucode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op_in,
    input  logic [3:0]  rd_in,
    input  logic [3:0]  rs_in,
    input  logic [15:0] imm_in,
    input  logic        issue,
    input  logic        ucode_flag,
    input  logic [3:0]  ghost_PC,
    output logic [31:0] ghost_instruction,
    output logic        ucode_done,
    output logic        busy,
    output logic        seq_err
);

    state_t      state;
    logic [6:0]  cap_op;
    logic [3:0]  cap_rd;
    logic [3:0]  cap_rs;
    logic [15:0] cap_imm;
    logic [3:0]  step;

    logic [31:0] tmpl_word;
    logic [4:0]  len;
    logic        run;
    logic        in_range;

    ucode_rom u_rom (
        .op       (cap_op),
        .line     (ghost_PC),
        .template (tmpl_word)
    );

    function automatic logic [3:0] sel_reg(input logic [3:0] sel, input logic [3:0] rd,
                                           input logic [3:0] rs);
        logic [3:0] r;
        case (sel)
            SEL_RD:  r = rd;
            SEL_RS:  r = rs;
            default: r = sel;
        endcase
        return r;
    endfunction

    assign run      = (state == RUN);
    assign len      = routine_len(cap_op);
    assign in_range = ({1'b0, ghost_PC} < len);
    assign busy     = run;

    always_comb begin
        ghost_instruction = NOP_WORD;
        ucode_done        = 1'b0;
        if (run && in_range) begin
            ghost_instruction = {tmpl_word[31:25],
                                 sel_reg(tmpl_word[24:21], cap_rd, cap_rs),
                                 sel_reg(tmpl_word[20:17], cap_rd, cap_rs),
                                 1'b0,
                                 tmpl_word[16] ? cap_imm : tmpl_word[15:0]};
            ucode_done        = ({1'b0, ghost_PC} == (len - 5'd1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cap_op  <= '0;
            cap_rd  <= '0;
            cap_rs  <= '0;
            cap_imm <= '0;
            step    <= '0;
            seq_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue && is_mul_op(op_in)) begin
                        cap_op  <= op_in;
                        cap_rd  <= rd_in;
                        cap_rs  <= rs_in;
                        cap_imm <= imm_in;
                        step    <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (ucode_flag) begin
                        step <= step + 4'd1;
                        if ((ghost_PC != step) || !in_range)
                            seq_err <= 1'b1;
                        if (ucode_done)
                            state <= IDLE;
                    end else begin
                        // Fetch abandoned the routine (left sUcode early or was reset)
                        seq_err <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: a routine-level reference model checked every cycle,
// plus hand-computed literal expectations for key cycles.
module tb_ucode_sequencer;

    localparam logic [31:0] NOP = 32'hC800_0000;
    localparam logic [6:0] M_SR = 7'b0010000;
    localparam logic [6:0] M_UR = 7'b0011000;
    localparam logic [6:0] M_SI = 7'b0110000;
    localparam logic [6:0] M_UI = 7'b0111000;
    localparam logic [6:0] U_MOV = 7'd1, U_ADD = 7'd2, U_SHL = 7'd3, U_SHR = 7'd4;
    localparam logic [6:0] U_AND = 7'd5, U_LDI = 7'd6, U_NEG = 7'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  op_in;
    logic [3:0]  rd_in;
    logic [3:0]  rs_in;
    logic [15:0] imm_in;
    logic        issue;
    logic        ucode_flag;
    logic [3:0]  ghost_PC;
    logic [31:0] ghost_instruction;
    logic        ucode_done;
    logic        busy;
    logic        seq_err;

    ucode_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .op_in             (op_in),
        .rd_in             (rd_in),
        .rs_in             (rs_in),
        .imm_in            (imm_in),
        .issue             (issue),
        .ucode_flag        (ucode_flag),
        .ghost_PC          (ghost_PC),
        .ghost_instruction (ghost_instruction),
        .ucode_done        (ucode_done),
        .busy              (busy),
        .seq_err           (seq_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] tbl [4][16];
    int          tlen [4];

    bit          m_run  = 1'b0;
    bit          m_err  = 1'b0;
    logic [6:0]  m_op   = '0;
    logic [3:0]  m_rd   = '0;
    logic [3:0]  m_rs   = '0;
    logic [15:0] m_imm  = '0;
    int          m_next = 0;

    function automatic int op_index(input logic [6:0] op);
        case (op)
            M_SR:    return 0;
            M_UR:    return 1;
            M_SI:    return 2;
            M_UI:    return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] u, input logic [3:0] a,
                                       input logic [3:0] b, input logic s,
                                       input logic [15:0] k);
        return {u, a, b, s, k};
    endfunction

    function automatic logic [3:0] pick(input logic [3:0] sel);
        if (sel == 4'hF) return m_rd;
        if (sel == 4'hE) return m_rs;
        return sel;
    endfunction

    function automatic logic [31:0] exp_word(input logic [3:0] pc);
        logic [31:0] t;
        int idx;
        if (!m_run) return NOP;
        idx = op_index(m_op);
        if (int'(pc) >= tlen[idx]) return NOP;
        t = tbl[idx][pc];
        return {t[31:25], pick(t[24:21]), pick(t[20:17]), 1'b0, t[16] ? m_imm : t[15:0]};
    endfunction

    function automatic bit exp_done(input logic [3:0] pc);
        if (!m_run) return 1'b0;
        return int'(pc) == tlen[op_index(m_op)] - 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: one step of the fetch/sequencer protocol per clock
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run  <= 1'b0;
            m_err  <= 1'b0;
            m_op   <= '0;
            m_rd   <= '0;
            m_rs   <= '0;
            m_imm  <= '0;
            m_next <= 0;
        end else if (!m_run) begin
            if (issue && op_index(op_in) >= 0) begin
                m_run  <= 1'b1;
                m_op   <= op_in;
                m_rd   <= rd_in;
                m_rs   <= rs_in;
                m_imm  <= imm_in;
                m_next <= 0;
            end
        end else if (ucode_flag) begin
            if (int'(ghost_PC) != m_next || int'(ghost_PC) >= tlen[op_index(m_op)])
                m_err <= 1'b1;
            m_next <= m_next + 1;
            if (exp_done(ghost_PC))
                m_run <= 1'b0;
        end else begin
            m_err <= 1'b1;
            m_run <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("model_ghost_instruction", ghost_instruction, exp_word(ghost_PC));
            check("model_ucode_done", {31'b0, ucode_done}, {31'b0, exp_done(ghost_PC)});
            check("model_busy", {31'b0, busy}, {31'b0, m_run});
            check("model_seq_err", {31'b0, seq_err}, {31'b0, m_err});
        end
    end

    task automatic set_in(input logic iss, input logic [6:0] op, input logic [3:0] rd,
                          input logic [3:0] rs, input logic [15:0] imm,
                          input logic flag, input logic [3:0] pc);
        issue      = iss;
        op_in      = op;
        rd_in      = rd;
        rs_in      = rs;
        imm_in     = imm;
        ucode_flag = flag;
        ghost_PC   = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        set_in(1'b0, 7'd0, 4'd0, 4'd0, 16'd0, 1'b0, 4'd0);
    endtask

    task automatic issue_op(input logic [6:0] op, input logic [3:0] rd, input logic [3:0] rs,
                            input logic [15:0] imm);
        set_in(1'b1, op, rd, rs, imm, 1'b0, 4'd0);
        tick();
    endtask

    task automatic line(input logic [3:0] pc);
        set_in(1'b0, 7'd0, 4'd0, 4'd0, 16'd0, 1'b1, pc);
    endtask

    task automatic full_routine(input logic [6:0] op, input logic [3:0] rd,
                                input logic [3:0] rs, input logic [15:0] imm);
        issue_op(op, rd, rs, imm);
        for (int p = 0; p < tlen[op_index(op)]; p++) begin
            line(4'(p));
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 16; j++)
                tbl[i][j] = NOP;
        tlen[0] = 8; tlen[1] = 6; tlen[2] = 4; tlen[3] = 3;
        tbl[0][0] = mk(U_ADD, 4'hF, 4'hE, 1'b0, 16'h0000);
        tbl[0][1] = mk(U_MOV, 4'h1, 4'hE, 1'b0, 16'h0000);
        tbl[0][2] = mk(U_LDI, 4'h2, 4'h0, 1'b0, 16'h0010);
        tbl[0][3] = mk(U_AND, 4'h3, 4'h1, 1'b0, 16'h0001);
        tbl[0][4] = mk(U_SHL, 4'h1, 4'h1, 1'b0, 16'h0001);
        tbl[0][5] = mk(U_SHR, 4'hE, 4'hE, 1'b0, 16'h0001);
        tbl[0][6] = mk(U_NEG, 4'hF, 4'hF, 1'b0, 16'h0000);
        tbl[0][7] = mk(U_ADD, 4'hF, 4'h2, 1'b0, 16'h0000);
        tbl[1][0] = mk(U_MOV, 4'h1, 4'hF, 1'b0, 16'h0000);
        tbl[1][1] = mk(U_MOV, 4'h2, 4'hE, 1'b0, 16'h0000);
        tbl[1][2] = mk(U_LDI, 4'hF, 4'h0, 1'b0, 16'h0000);
        tbl[1][3] = mk(U_AND, 4'h3, 4'h2, 1'b0, 16'h0001);
        tbl[1][4] = mk(U_SHL, 4'h1, 4'h1, 1'b0, 16'h0001);
        tbl[1][5] = mk(U_ADD, 4'hF, 4'h1, 1'b0, 16'h0000);
        tbl[2][0] = mk(U_LDI, 4'h2, 4'h0, 1'b1, 16'h0000);
        tbl[2][1] = mk(U_MOV, 4'h1, 4'hE, 1'b0, 16'h0000);
        tbl[2][2] = mk(U_SHL, 4'h1, 4'h1, 1'b0, 16'h0004);
        tbl[2][3] = mk(U_ADD, 4'hF, 4'h1, 1'b1, 16'h0000);
        tbl[3][0] = mk(U_LDI, 4'h2, 4'h0, 1'b1, 16'h0000);
        tbl[3][1] = mk(U_AND, 4'hF, 4'hE, 1'b0, 16'hFFFF);
        tbl[3][2] = mk(U_ADD, 4'hF, 4'h2, 1'b0, 16'h0000);

        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ghost", ghost_instruction, NOP);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, ucode_done}, 32'd0);
        check("reset_seq_err", {31'b0, seq_err}, 32'd0);
        #1;
        rst = 1'b1;
        tick();

        // Capture and substitution on line 0, then the full LEN=8 routine
        issue_op(M_SR, 4'd3, 4'd5, 16'h0000);
        line(4'd0);
        #1;
        check("sr_line0", ghost_instruction, 32'h046A_0000);
        check("sr_busy_t1", {31'b0, busy}, 32'd1);
        tick();
        for (int p = 1; p < 8; p++) begin
            line(4'(p));
            #1;
            if (p == 6) check("sr_done_pc6", {31'b0, ucode_done}, 32'd0);
            if (p == 7) check("sr_done_pc7", {31'b0, ucode_done}, 32'd1);
            tick();
        end
        idle();
        #1;
        check("sr_after_busy", {31'b0, busy}, 32'd0);
        check("sr_after_nop", ghost_instruction, NOP);
        tick();

        // Immediate substitution
        issue_op(M_SI, 4'd4, 4'd6, 16'h00FF);
        line(4'd0);
        #1;
        check("si_line0_imm", ghost_instruction, 32'h0C40_00FF);
        tick();
        for (int p = 1; p < 4; p++) begin
            line(4'(p));
            tick();
        end
        idle();
        tick();

        full_routine(M_UI, 4'hA, 4'hB, 16'h1234);
        full_routine(M_SR, 4'hC, 4'h0, 16'hBEEF);
        full_routine(M_UR, 4'h2, 4'hD, 16'h0000);

        // Non-multiply opcode ignored; re-issue during RUN ignored
        issue_op(7'b1100000, 4'd1, 4'd1, 16'h0000);
        idle();
        #1;
        check("nonmul_idle", {31'b0, busy}, 32'd0);
        tick();
        issue_op(M_UR, 4'd7, 4'd9, 16'h0000);
        set_in(1'b1, M_SR, 4'd2, 4'd4, 16'h5555, 1'b1, 4'd0);
        #1;
        check("ur_line0_rd", ghost_instruction, 32'h022E_0000);
        tick();
        set_in(1'b1, M_SR, 4'd2, 4'd4, 16'h5555, 1'b1, 4'd1);
        #1;
        check("ur_line1_rs", ghost_instruction, 32'h0252_0000);
        tick();
        for (int p = 2; p < 6; p++) begin
            line(4'(p));
            tick();
        end
        idle();
        tick();

        // ghost_PC skips 2 -> 4
        issue_op(M_SR, 4'd1, 4'd2, 16'h0000);
        for (int p = 0; p < 8; p++) begin
            if (p == 3) continue;
            line(4'(p));
            #1;
            if (p == 4) check("jump_err_before", {31'b0, seq_err}, 32'd0);
            if (p == 5) check("jump_err_after", {31'b0, seq_err}, 32'd1);
            tick();
        end
        idle();
        #1;
        check("jump_err_idle", {31'b0, seq_err}, 32'd1);
        tick();

        // Line beyond routine end, held until ucode_flag drops
        issue_op(M_UI, 4'd5, 4'd6, 16'hA5A5);
        line(4'd0); tick();
        line(4'd1); tick();
        line(4'd3);
        #1;
        check("oor_nop", ghost_instruction, NOP);
        check("oor_done", {31'b0, ucode_done}, 32'd0);
        tick();
        line(4'd4);
        #1;
        check("oor_still_busy", {31'b0, busy}, 32'd1);
        tick();
        idle();
        tick();

        // Fetch leaves sUcode early
        issue_op(M_UR, 4'd3, 4'd4, 16'h0000);
        line(4'd0); tick();
        line(4'd1); tick();
        idle();
        tick();
        #1;
        check("early_exit_busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset mid-routine
        tick();
        issue_op(M_SR, 4'd8, 4'd9, 16'h0000);
        line(4'd0); tick();
        line(4'd1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_ghost", ghost_instruction, NOP);
        check("arst_seq_err", {31'b0, seq_err}, 32'd0);
        check("arst_done", {31'b0, ucode_done}, 32'd0);
        idle();
        tick();
        rst = 1'b1;
        tick();

        full_routine(M_SI, 4'hF, 4'h1, 16'h7FFF);
        #1;
        check("final_seq_err", {31'b0, seq_err}, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
